// File: rtl/layer_sequencer.sv
// layer_sequencer: batch controller for a conv -> pool -> dense engine chain.
// For each image in a batch it triggers the three engines in order. Between the
// triggers it waits for each engine's completion pulse. It also hands the
// feature-map RAM port to whichever engine is active.
// A per-stage watchdog sends the block to ERROR if an engine never finishes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, num_images     begin a batch of num_images images (0 runs one image)
//   abort                 cancel the batch in progress, return to IDLE
//   err_clear             leave ERROR
//   conv/pool/dense_done  engine completion pulses
//   conv/pool/dense_start one-cycle engine triggers (registered)
//   ram_sel               RAM owner: 0 host, 1 conv, 2 pool, 3 dense
//   busy, done, error     status; done is a one-cycle end-of-batch pulse
//   err_stage             stage that timed out: 1 conv, 2 pool, 3 dense
//   img_idx               index of the image being processed
module layer_sequencer #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_images,
  input  logic       abort,
  input  logic       err_clear,
  input  logic       conv_done,
  input  logic       pool_done,
  input  logic       dense_done,
  output logic       conv_start,
  output logic       pool_start,
  output logic       dense_start,
  output logic [1:0] ram_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_stage,
  output logic [7:0] img_idx
);

  typedef enum logic [2:0] {
    IDLE, C_GO, C_WAIT, P_GO, P_WAIT, D_GO, D_WAIT, ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] wd_q, wd_d;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           err_stage_q, err_stage_d;
  logic                 done_q, done_d;
  logic                 conv_start_q, conv_start_d;
  logic                 pool_start_q, pool_start_d;
  logic                 dense_start_q, dense_start_d;
  logic [1:0]           ram_sel_q, ram_sel_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;

  logic timeout;
  logic last_img;
  logic active;

  assign timeout  = (wd_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  // 9-bit compare so idx 255 + 1 does not wrap onto a count of 0.
  assign last_img = (({1'b0, idx_q} + 9'd1) == {1'b0, cnt_q});
  assign active   = (state_q != IDLE) && (state_q != ERROR);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= 8'd1;
      err_stage_q   <= '0;
      done_q        <= 1'b0;
      conv_start_q  <= 1'b0;
      pool_start_q  <= 1'b0;
      dense_start_q <= 1'b0;
      ram_sel_q     <= '0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_stage_q   <= err_stage_d;
      done_q        <= done_d;
      conv_start_q  <= conv_start_d;
      pool_start_q  <= pool_start_d;
      dense_start_q <= dense_start_d;
      ram_sel_q     <= ram_sel_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end

  // Next-state logic. Abort outranks engine completion and the watchdog.
  // Inside a WAIT state, completion outranks the watchdog.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_stage_d = err_stage_q;
    done_d      = 1'b0;
    if (abort && active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cnt_d   = (num_images == 8'd0) ? 8'd1 : num_images;
          idx_d   = '0;
          state_d = C_GO;
        end
        C_GO: begin
          wd_d    = '0;
          state_d = C_WAIT;
        end
        C_WAIT: begin
          if (conv_done)    state_d = P_GO;
          else if (timeout) begin state_d = ERROR; err_stage_d = 2'd1; end
          else              wd_d = wd_q + 1'b1;
        end
        P_GO: begin
          wd_d    = '0;
          state_d = P_WAIT;
        end
        P_WAIT: begin
          if (pool_done)    state_d = D_GO;
          else if (timeout) begin state_d = ERROR; err_stage_d = 2'd2; end
          else              wd_d = wd_q + 1'b1;
        end
        D_GO: begin
          wd_d    = '0;
          state_d = D_WAIT;
        end
        D_WAIT: begin
          if (dense_done) begin
            if (last_img) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = C_GO;
            end
          end else if (timeout) begin
            state_d     = ERROR;
            err_stage_d = 2'd3;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        ERROR: if (err_clear) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The outputs are decoded from the next state and then registered.
  // They change on the same edge as the state and stay glitch-free.
  always_comb begin
    conv_start_d  = (state_d == C_GO);
    pool_start_d  = (state_d == P_GO);
    dense_start_d = (state_d == D_GO);
    busy_d        = (state_d != IDLE) && (state_d != ERROR);
    error_d       = (state_d == ERROR);
    unique case (state_d)
      C_GO, C_WAIT: ram_sel_d = 2'd1;
      P_GO, P_WAIT: ram_sel_d = 2'd2;
      D_GO, D_WAIT: ram_sel_d = 2'd3;
      default:      ram_sel_d = 2'd0;
    endcase
  end

  assign conv_start  = conv_start_q;
  assign pool_start  = pool_start_q;
  assign dense_start = dense_start_q;
  assign ram_sel     = ram_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_stage   = err_stage_q;
  assign img_idx     = idx_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 16-cycle watchdog.
module tb_layer_sequencer;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, start, abort, err_clear;
  logic       conv_done, pool_done, dense_done;
  logic [7:0] num_images;
  logic       conv_start, pool_start, dense_start;
  logic [1:0] ram_sel, err_stage;
  logic       busy, done, error;
  logic [7:0] img_idx;

  layer_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .num_images(num_images),
    .abort(abort), .err_clear(err_clear),
    .conv_done(conv_done), .pool_done(pool_done), .dense_done(dense_done),
    .conv_start(conv_start), .pool_start(pool_start), .dense_start(dense_start),
    .ram_sel(ram_sel), .busy(busy), .done(done), .error(error),
    .err_stage(err_stage), .img_idx(img_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Engine model and event log, filled by run_engines
  int n_conv, n_pool, n_dense, n_done, gap, last_dd, cd, pd, dd;
  logic [1:0] rs_prev;
  logic [1:0] rs_log[$];
  byte unsigned st_log[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Caller sets start/num_images first. Engines answer 5 cycles after their start.
  // The task returns when done is seen or after max_cyc cycles.
  task automatic run_engines(input int max_cyc);
    n_conv = 0; n_pool = 0; n_dense = 0; n_done = 0;
    gap = -1; last_dd = -1; cd = 0; pd = 0; dd = 0;
    rs_prev = 2'd0; rs_log.delete(); st_log.delete();
    for (int k = 0; k < max_cyc; k++) begin
      step;
      start = 1'b0;
      if (ram_sel !== rs_prev) begin rs_log.push_back(ram_sel); rs_prev = ram_sel; end
      if (done === 1'b1) begin n_done++; break; end
      conv_done = 1'b0; pool_done = 1'b0; dense_done = 1'b0;
      if (cd > 0) begin cd--; conv_done = (cd == 0); end
      if (pd > 0) begin pd--; pool_done = (pd == 0); end
      if (dd > 0) begin dd--; dense_done = (dd == 0); if (dd == 0) last_dd = k; end
      if (conv_start === 1'b1) begin
        n_conv++; st_log.push_back("C"); cd = 5;
        if (gap < 0 && last_dd >= 0) gap = k - last_dd;
      end
      if (pool_start === 1'b1)  begin n_pool++;  st_log.push_back("P"); pd = 5; end
      if (dense_start === 1'b1) begin n_dense++; st_log.push_back("D"); dd = 5; end
    end
    conv_done = 1'b0; pool_done = 1'b0; dense_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b exp 0", busy); end
    vectors++; if (ram_sel !== 2'd0) begin miscompares++; $display("FAIL rst_ram_sel got %0d exp 0", ram_sel); end
    vectors++; if ({conv_start, pool_start, dense_start, done, error} !== 5'b0) begin miscompares++; $display("FAIL rst_pulses got %b exp 00000", {conv_start, pool_start, dense_start, done, error}); end
    vectors++; if (err_stage !== 2'd0) begin miscompares++; $display("FAIL rst_err_stage got %0d exp 0", err_stage); end
    vectors++; if (img_idx !== 8'd0) begin miscompares++; $display("FAIL rst_img_idx got %0d exp 0", img_idx); end
  endtask

  task automatic test_basic_batch;
    logic [1:0] exp_rs[7];
    string exp_st;
    exp_rs = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_st = "CPDCPD";
    num_images = 8'd2;
    start = 1'b1;
    run_engines(80);
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL basic_done_cnt got %0d exp 1", n_done); end
    vectors++; if ({n_conv, n_pool, n_dense} !== {32'd2, 32'd2, 32'd2}) begin miscompares++; $display("FAIL basic_start_cnt got %0d/%0d/%0d exp 2/2/2", n_conv, n_pool, n_dense); end
    vectors++; if (st_log.size() !== 6) begin miscompares++; $display("FAIL basic_start_len got %0d exp 6", st_log.size()); end
    for (int i = 0; i < 6 && i < st_log.size(); i++) begin
      vectors++; if (st_log[i] !== exp_st[i]) begin miscompares++; $display("FAIL basic_start_order[%0d] got %c exp %c", i, st_log[i], exp_st[i]); end
    end
    vectors++; if (rs_log.size() !== 7) begin miscompares++; $display("FAIL basic_ram_sel_len got %0d exp 7", rs_log.size()); end
    for (int i = 0; i < 7 && i < rs_log.size(); i++) begin
      vectors++; if (rs_log[i] !== exp_rs[i]) begin miscompares++; $display("FAIL basic_ram_sel[%0d] got %0d exp %0d", i, rs_log[i], exp_rs[i]); end
    end
    vectors++; if (gap !== 1) begin miscompares++; $display("FAIL basic_dense_to_conv got %0d exp 1", gap); end
    vectors++; if (img_idx !== 8'd1) begin miscompares++; $display("FAIL basic_img_idx got %0d exp 1", img_idx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %0b exp 0", busy); end
    step;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got %0b exp 0", done); end
  endtask

  task automatic test_zero_count;
    num_images = 8'd0;
    start = 1'b1;
    run_engines(60);
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL zero_done_cnt got %0d exp 1", n_done); end
    vectors++; if (n_conv !== 1) begin miscompares++; $display("FAIL zero_conv_cnt got %0d exp 1", n_conv); end
    vectors++; if (n_dense !== 1) begin miscompares++; $display("FAIL zero_dense_cnt got %0d exp 1", n_dense); end
    vectors++; if (img_idx !== 8'd0) begin miscompares++; $display("FAIL zero_img_idx got %0d exp 0", img_idx); end
    step;
  endtask

  task automatic test_collisions;
    num_images = 8'd1;
    start = 1'b1;
    step;                     // C_GO
    start = 1'b0;
    vectors++; if (conv_start !== 1'b1) begin miscompares++; $display("FAIL coll_conv_start got %0b exp 1", conv_start); end
    conv_done = 1'b1;         // arrives in the C_GO cycle
    step;                     // C_WAIT cycle 1
    conv_done = 1'b0;
    vectors++; if (ram_sel !== 2'd1 || pool_start !== 1'b0) begin miscompares++; $display("FAIL coll_go_done_ignored got ram_sel=%0d pool_start=%0b exp 1/0", ram_sel, pool_start); end
    repeat (TO - 1) step;     // C_WAIT cycle 16: watchdog at its limit
    vectors++; if (ram_sel !== 2'd1 || error !== 1'b0) begin miscompares++; $display("FAIL coll_pre_limit got ram_sel=%0d error=%0b exp 1/0", ram_sel, error); end
    conv_done = 1'b1;
    step;                     // P_GO
    conv_done = 1'b0;
    vectors++; if (pool_start !== 1'b1 || ram_sel !== 2'd2 || error !== 1'b0) begin miscompares++; $display("FAIL coll_done_wins got pool_start=%0b ram_sel=%0d error=%0b exp 1/2/0", pool_start, ram_sel, error); end
    abort = 1'b1;
    step;
    abort = 1'b0;
    vectors++; if (busy !== 1'b0 || ram_sel !== 2'd0 || done !== 1'b0 || dense_start !== 1'b0) begin miscompares++; $display("FAIL coll_abort got busy=%0b ram_sel=%0d done=%0b dstart=%0b exp 0/0/0/0", busy, ram_sel, done, dense_start); end
  endtask

  task automatic test_timeout;
    num_images = 8'd1;
    start = 1'b1;
    step;                     // C_GO
    start = 1'b0;
    step;                     // C_WAIT
    conv_done = 1'b1;
    step;                     // P_GO
    conv_done = 1'b0;
    repeat (TO) step;         // P_WAIT cycle 16
    vectors++; if (error !== 1'b0 || busy !== 1'b1 || ram_sel !== 2'd2) begin miscompares++; $display("FAIL to_last_wait got error=%0b busy=%0b ram_sel=%0d exp 0/1/2", error, busy, ram_sel); end
    step;                     // ERROR
    vectors++; if (error !== 1'b1 || err_stage !== 2'd2) begin miscompares++; $display("FAIL to_error got error=%0b err_stage=%0d exp 1/2", error, err_stage); end
    vectors++; if (busy !== 1'b0 || ram_sel !== 2'd0) begin miscompares++; $display("FAIL to_busy got busy=%0b ram_sel=%0d exp 0/0", busy, ram_sel); end
    start = 1'b1; abort = 1'b1;
    step;
    start = 1'b0; abort = 1'b0;
    vectors++; if (error !== 1'b1 || conv_start !== 1'b0) begin miscompares++; $display("FAIL to_start_ignored got error=%0b conv_start=%0b exp 1/0", error, conv_start); end
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    vectors++; if (error !== 1'b0 || busy !== 1'b0 || err_stage !== 2'd2) begin miscompares++; $display("FAIL to_clear got error=%0b busy=%0b err_stage=%0d exp 0/0/2", error, busy, err_stage); end
  endtask

  task automatic test_abort;
    num_images = 8'd2;
    start = 1'b1;
    step;                     // C_GO
    start = 1'b0;
    step;                     // C_WAIT
    conv_done = 1'b1;
    step;                     // P_GO
    conv_done = 1'b0;
    step;                     // P_WAIT
    pool_done = 1'b1;
    step;                     // D_GO
    pool_done = 1'b0;
    vectors++; if (dense_start !== 1'b1 || ram_sel !== 2'd3) begin miscompares++; $display("FAIL ab_dense_go got dstart=%0b ram_sel=%0d exp 1/3", dense_start, ram_sel); end
    step;                     // D_WAIT
    abort = 1'b1; dense_done = 1'b1;
    step;
    abort = 1'b0; dense_done = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || ram_sel !== 2'd0 || conv_start !== 1'b0) begin miscompares++; $display("FAIL ab_idle got busy=%0b done=%0b ram_sel=%0d cstart=%0b exp 0/0/0/0", busy, done, ram_sel, conv_start); end
    vectors++; if (img_idx !== 8'd0) begin miscompares++; $display("FAIL ab_img_idx got %0d exp 0", img_idx); end
    step;
    vectors++; if (done !== 1'b0 || conv_start !== 1'b0) begin miscompares++; $display("FAIL ab_quiet got done=%0b cstart=%0b exp 0/0", done, conv_start); end
    num_images = 8'd2;
    start = 1'b1;
    run_engines(80);
    vectors++; if (n_done !== 1 || n_conv !== 2) begin miscompares++; $display("FAIL ab_restart got done=%0d conv=%0d exp 1/2", n_done, n_conv); end
    vectors++; if (img_idx !== 8'd1) begin miscompares++; $display("FAIL ab_restart_idx got %0d exp 1", img_idx); end
    step;
  endtask

  task automatic test_reset_mid_batch;
    num_images = 8'd3;
    start = 1'b1;
    run_engines(20);          // ends in C_WAIT of image 1
    vectors++; if (img_idx !== 8'd1 || ram_sel !== 2'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL rm_pre got idx=%0d ram_sel=%0d busy=%0b exp 1/1/1", img_idx, ram_sel, busy); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || ram_sel !== 2'd0 || img_idx !== 8'd0) begin miscompares++; $display("FAIL rm_state got busy=%0b ram_sel=%0d idx=%0d exp 0/0/0", busy, ram_sel, img_idx); end
    vectors++; if ({conv_start, pool_start, dense_start, done, error, err_stage} !== 7'b0) begin miscompares++; $display("FAIL rm_outputs got %b exp 0000000", {conv_start, pool_start, dense_start, done, error, err_stage}); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; err_clear = 1'b0;
    conv_done = 1'b0; pool_done = 1'b0; dense_done = 1'b0;
    num_images = 8'd0;
    test_reset;
    test_basic_batch;
    test_zero_count;
    test_collisions;
    test_timeout;
    test_abort;
    test_reset_mid_batch;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65536: per-stage watchdog limit in clock cycles.
REQ-002 SHALL have parameter CNT_WIDTH, default 17: watchdog counter width; must be at least clog2(TIMEOUT_CYCLES)+1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a batch; sampled only in IDLE.
REQ-006 SHALL have port num_images, input, 8 bits: batch size, latched when start is accepted.
REQ-007 SHALL have port abort, input, 1 bit: cancel any batch in progress.
REQ-008 SHALL have port err_clear, input, 1 bit: leave ERROR.
REQ-009 SHALL have ports conv_done, pool_done and dense_done, inputs, 1 bit each: engine completion pulses.
REQ-010 SHALL have ports conv_start, pool_start and dense_start, outputs, 1 bit each: registered one-cycle engine triggers.
REQ-011 SHALL have port ram_sel, output, 2 bits: feature-map RAM port owner; 0 = host, 1 = conv, 2 = pool, 3 = dense.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE and ERROR.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the batch completes.
REQ-014 SHALL have port error, output, 1 bit: high while in ERROR.
REQ-015 SHALL have port err_stage, output, 2 bits: stage that timed out; 1 = conv, 2 = pool, 3 = dense.
REQ-016 SHALL have port img_idx, output, 8 bits: index of the image currently being processed.

Function
REQ-017 SHALL implement these states: IDLE, C_GO, C_WAIT, P_GO, P_WAIT, D_GO, D_WAIT, ERROR.
REQ-018 IDLE: when start=1, SHALL latch num_images (a value of 0 is latched as 1), clear img_idx to 0, and go to C_GO.
REQ-019 C_GO, P_GO and D_GO SHALL each last exactly one cycle, assert the matching *_start for that cycle only, and then go to the matching *_WAIT state.
REQ-020 ram_sel SHALL equal 1 in C_GO/C_WAIT, 2 in P_GO/P_WAIT, 3 in D_GO/D_WAIT, and 0 otherwise; it SHALL change in the same cycle as the state.
REQ-021 C_WAIT: conv_done=1 SHALL cause a transition to P_GO. P_WAIT: pool_done=1 SHALL cause a transition to D_GO.
REQ-022 D_WAIT with dense_done=1:
- if img_idx+1 equals the latched count: pulse done, go to IDLE, hold img_idx;
- otherwise: increment img_idx and go to C_GO.
REQ-023 Done inputs SHALL be ignored outside their own WAIT state, including a done pulse that arrives in the *_GO cycle.
REQ-024 Watchdog counter:
- cleared on entry to each WAIT state;
- incremented every cycle spent in that WAIT state;
- if it reaches TIMEOUT_CYCLES-1 with no done, the next state SHALL be ERROR and err_stage SHALL be loaded.
REQ-025 If a done input and a timeout occur in the same cycle, done SHALL win and the normal transition SHALL be taken.
REQ-026 abort=1 in any state other than IDLE or ERROR SHALL force IDLE on the next edge, with no done pulse and no *_start pulse; img_idx SHALL be held.
REQ-027 abort SHALL take priority over done inputs and over the watchdog.
REQ-028 ERROR: SHALL ignore start and abort, and go to IDLE when err_clear=1; err_stage SHALL be held until the next timeout or reset.
REQ-029 Within a batch, the state sequence SHALL be strictly conv, pool, dense per image; no stage may be skipped or reordered.
REQ-030 From dense_done of one image to conv_start of the next image SHALL take exactly 1 cycle.

Reset
REQ-031 rst=1 SHALL force, on the next edge: state IDLE, all *_start=0, ram_sel=0, busy=0, done=0, error=0, err_stage=0, img_idx=0, watchdog=0, latched count=1.
REQ-032 Reset SHALL override every other input, including reset asserted mid-batch.

Verification
REQ-033 Basic batch: start with num_images=2, each engine returns done 5 cycles after its start -> exactly two conv_start, two pool_start and two dense_start pulses in order; ram_sel steps 1,2,3,1,2,3,0; a single done pulse; img_idx reads 1 at the end.
REQ-034 Zero count: num_images=0 -> exactly one image is processed and done pulses once.
REQ-035 Timeout: TIMEOUT_CYCLES=16, pool_done is never driven -> error=1 and err_stage=2 after 16 cycles in P_WAIT; busy=0; start is ignored; err_clear returns the block to IDLE.
REQ-036 Boundary collisions:
- conv_done in the C_GO cycle is ignored and a second conv_done is required;
- conv_done on the timeout cycle advances to P_GO with no error.
REQ-037 Abort: abort during D_WAIT of image 0 -> IDLE next cycle, no done pulse, ram_sel=0; a fresh start then runs normally with img_idx restarting at 0.
REQ-038 Reset mid-batch: rst during C_WAIT -> all outputs return to the REQ-031 values on the next edge.
